// File: rtl/image_loader_pkg.sv
// image_loader_pkg
//   Shared definitions for the image loader slice: default pixel width,
//   frame size and address width, the loader FSM state encoding and a small
//   edge-detect helper.
package image_loader_pkg;

  // Default geometry: 32x32 LeNet input frame of 8-bit pixels.
  localparam int unsigned WD_DEF    = 8;
  localparam int unsigned N_PIX_DEF = 1024;
  localparam int unsigned AW_DEF    = 10;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Rising edge of a level given its registered previous value.
  function automatic logic rising(input logic prev, input logic cur);
    return !prev && cur;
  endfunction

endpackage

// File: rtl/image_ram.sv
// image_ram
//   N_PIX x WD frame store. One synchronous write port and one synchronous
//   read port with an active-low read enable. A read and a write to the same
//   address in the same cycle returns the old contents. The read register is
//   cleared by reset; the array itself is never cleared.
//
// Ports
//   clk     clock, rising edge
//   rst     asynchronous active-high reset (read register only)
//   we_i    write enable
//   wa_i    write address
//   wd_i    write data
//   cena_i  active-low read enable
//   aa_i    read address
//   q_o     read data, valid the cycle after an enabled read
module image_ram
  import image_loader_pkg::*;
#(
  parameter int unsigned WD    = WD_DEF,
  parameter int unsigned N_PIX = N_PIX_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [WD-1:0] wd_i,
  input  logic          cena_i,
  input  logic [AW-1:0] aa_i,
  output logic [WD-1:0] q_o
);

  localparam logic [AW:0] DEPTH = (AW+1)'(N_PIX);

  logic [WD-1:0] mem [N_PIX];
  logic [WD-1:0] q_q;

  logic wr_in_range;
  logic rd_in_range;

  always_comb begin
    wr_in_range = ({1'b0, wa_i} < DEPTH);
    rd_in_range = ({1'b0, aa_i} < DEPTH);
  end

  // Out-of-range writes are dropped so an address past the frame cannot
  // alias onto a real pixel.
  always_ff @(posedge clk) begin
    if (we_i && wr_in_range) begin
      mem[wa_i] <= wd_i;
    end
  end

  // Out-of-range reads simply hold the previous output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (!cena_i && rd_in_range) begin
      q_q <= mem[aa_i];
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/image_loader.sv
// image_loader
//   Collects one frame of N_PIX pixels from a valid/ready stream into a
//   frame store, pulses go to the LeNet core, then waits for the core to
//   raise its ready level before accepting the next frame. LeNet reads the
//   frame store through a synchronous, active-low-enabled read port.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   s_valid      upstream pixel valid
//   s_ready      loader accepts pixel (registered)
//   s_data       pixel value
//   s_last       marks the final pixel of a frame
//   go           one-cycle start pulse to LeNet
//   lenet_ready  LeNet completion level
//   cena_image   active-low read enable from LeNet
//   aa_image     read address from LeNet
//   qa           read data to LeNet
//   busy         high from go until the frame is released
//   err_len      sticky frame-length error, cleared only by reset
module image_loader
  import image_loader_pkg::*;
#(
  parameter int unsigned WD    = WD_DEF,
  parameter int unsigned N_PIX = N_PIX_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [WD-1:0] s_data,
  input  logic          s_last,
  output logic          go,
  input  logic          lenet_ready,
  input  logic          cena_image,
  input  logic [AW-1:0] aa_image,
  output logic [WD-1:0] qa,
  output logic          busy,
  output logic          err_len
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_PIX - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic          s_ready_q;
  logic          go_q;
  logic          busy_q;
  logic          err_len_q;
  logic          lr_prev_q;

  logic accept;
  logic last_beat;
  logic lr_rise;

  always_comb begin
    accept    = s_valid && s_ready_q;
    last_beat = (wr_ptr_q == LAST_ADDR);
    lr_rise   = rising(lr_prev_q, lenet_ready);
  end

  // All outputs are registered alongside the state so that s_ready, go and
  // busy change on the same edge as the state they belong to. s_ready is
  // therefore low throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      wr_ptr_q  <= '0;
      s_ready_q <= 1'b0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_len_q <= 1'b0;
      lr_prev_q <= 1'b0;
    end else begin
      lr_prev_q <= lenet_ready;
      go_q      <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            if (last_beat) begin
              // Frame complete regardless of s_last; a missing s_last is
              // only flagged.
              state_q   <= ST_FIRE;
              wr_ptr_q  <= '0;
              s_ready_q <= 1'b0;
              go_q      <= 1'b1;
              busy_q    <= 1'b1;
              if (!s_last) begin
                err_len_q <= 1'b1;
              end
            end else if (s_last) begin
              // Short frame: drop it and restart at pixel 0.
              wr_ptr_q  <= '0;
              err_len_q <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
          end
        end
        ST_FIRE: begin
          s_ready_q <= 1'b0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          // A level already high on entry does not release the frame; only
          // a fresh 0->1 transition does.
          if (lr_rise) begin
            state_q   <= ST_LOAD;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b1;
          end else begin
            s_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_LOAD;
          wr_ptr_q  <= '0;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  image_ram #(
    .WD    (WD),
    .N_PIX (N_PIX),
    .AW    (AW)
  ) u_image_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (accept),
    .wa_i   (wr_ptr_q),
    .wd_i   (s_data),
    .cena_i (cena_image),
    .aa_i   (aa_image),
    .q_o    (qa)
  );

  assign s_ready = s_ready_q;
  assign go      = go_q;
  assign busy    = busy_q;
  assign err_len = err_len_q;

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter WD, default `WD (global.v), pixel width in bits.
REQ-002 Parameter N_PIX, default 1024, pixels per frame (32x32 LeNet input).
REQ-003 Parameter AW, default 10, image address width; N_PIX SHALL be <= 2**AW.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 s_valid  in  1  upstream pixel valid.
REQ-007 s_ready  out  1  loader accepts pixel.
REQ-008 s_data  in  WD  pixel value.
REQ-009 s_last  in  1  marks final pixel of a frame.
REQ-010 go  out  1  one-cycle start pulse to lenet.
REQ-011 lenet_ready  in  1  lenet completion level (lenet "ready").
REQ-012 cena_image  in  1  active-low read enable from lenet.
REQ-013 aa_image  in  AW  read address from lenet.
REQ-014 qa  out  WD  read data to lenet conv1_image.
REQ-015 busy  out  1  high from go until frame completion.
REQ-016 err_len  out  1  sticky frame-length error flag.

Function
REQ-017 Beat accepted iff s_valid && s_ready in same cycle; s_data written to mem[wr_ptr], wr_ptr increments.
REQ-018 FSM states LOAD, FIRE, WAIT; reset state LOAD.
REQ-019 LOAD: s_ready=1; accepted beat at wr_ptr==N_PIX-1 -> FIRE, wr_ptr cleared to 0.
REQ-020 LOAD: accepted beat with s_last=1 and wr_ptr<N_PIX-1 -> err_len=1, wr_ptr cleared to 0, remain LOAD (frame dropped, no go).
REQ-021 LOAD: final beat (wr_ptr==N_PIX-1) with s_last=0 -> err_len=1, frame still completed (-> FIRE).
REQ-022 FIRE: go=1 exactly one cycle, s_ready=0, busy=1; next state WAIT.
REQ-023 WAIT: s_ready=0, busy=1; leave to LOAD on lenet_ready rising edge (registered previous 0, current 1); busy drops same edge.
REQ-024 lenet_ready high on entry to WAIT SHALL NOT complete the frame; a 0->1 transition is required.
REQ-025 go latency: first cycle after the accepting edge of the final beat.
REQ-026 Read port: cena_image==0 at edge -> qa = mem[aa_image] after that edge (1-cycle latency); cena_image==1 -> qa holds.
REQ-027 Read and write same address same cycle: qa returns old data.
REQ-028 Reads legal in any state; only WAIT guarantees a stable complete frame.
REQ-029 aa_image >= N_PIX: qa value undefined, no side effects.
REQ-030 err_len cleared only by rst.

Reset
REQ-031 rst asserted: state LOAD, wr_ptr=0, go=0, busy=0, err_len=0, qa=0, lenet_ready history=0; s_ready=0 while rst high, 1 first cycle after release.
REQ-032 rst mid-frame or in WAIT: partial frame discarded, no go emitted; memory contents not cleared.

Structure
REQ-033 WD, N_PIX, AW defaults and FSM state encodings SHALL live in shared global.v.
REQ-034 Storage SHALL be sub-module image_ram: N_PIX x WD, one sync write port, one sync read port with active-low enable.
REQ-035 Control (FSM, wr_ptr, edge detect) SHALL be in image_loader only.

Verification
REQ-036 Stream 1024 pixels value=index[7:0], s_last on 1024th -> go single pulse 1 cycle after last beat, err_len=0, read addr 5 returns 5.
REQ-037 s_valid toggled randomly 50% -> identical memory contents and single go as REQ-036.
REQ-038 s_last on beat 100 -> err_len=1, no go, next full 1024-beat frame fires go normally.
REQ-039 In WAIT hold lenet_ready=1 then 0 then 1 -> exit only on 0->1 edge; s_ready=0 throughout WAIT.
REQ-040 rst pulse after 500 beats -> go never asserted, wr_ptr restarts 0, s_ready=1 cycle after release.
REQ-041 cena_image=1 with aa_image changing -> qa unchanged; cena_image=0 addr 1023 -> qa=mem[1023] next cycle.
